asteroid_field: RTL and testbench
=================================

// Module: asteroid_field
// PURPOSE
//  Parametrised multi-asteroid generator for the VGA playfield: up to N_ROCKS squares spawn at
//  pseudo-random columns, fall SPEED lines per frame and retire at the bottom boundary.
//  Sits beside the sync counter; pixel_on feeds the colour mux, kill_mask comes from collision logic.
// PARAMETERS
//  N_ROCKS        4       asteroid slots (1..8)
//  SIZE           30      square edge length, pixels
//  SPEED          1       lines moved per frame tick (1..15)
//  LEFT_BOUND     144     first visible HCounter value
//  RIGHT_BOUND    784     last visible HCounter value + 1
//  TOP_BOUND      35      spawn top line
//  BOTTOM_BOUND   515     retire line; a rock retires when bottom (top+SIZE) >= BOTTOM_BOUND
//  SPAWN_FRAMES   60      frame ticks between spawn attempts
//  LFSR_SEED      16'hACE1 LFSR reset value; must be non-zero
// PORTS
//  clk          in   1        pixel clock
//  resetn       in   1        asynchronous active-low reset
//  HCounter     in   10       horizontal pixel counter from sync generator
//  VCounter     in   10       vertical line counter from sync generator
//  enable       in   1        1 = spawn and motion run; 0 = everything frozen in place
//  kill_mask    in   N_ROCKS  bit i high for one clk retires rock i
//  pixel_on     out  1        current pixel lies inside any falling rock (registered)
//  rock_id      out  3        index of the lowest-numbered rock covering the pixel; 0 when none
//  active_count out  4        number of slots in FALLING
//  escaped      out  1        one-clk pulse when any rock reaches BOTTOM_BOUND
// BEHAVIOUR
//  Reset: all slots IDLE, top=TOP_BOUND, x=LEFT_BOUND, spawn timer=0, LFSR=LFSR_SEED;
//   pixel_on=0, rock_id=0, active_count=0, escaped=0.
//  Frame tick: internal one-clk strobe when HCounter==0 && VCounter==0 and previous-clk HCounter!=0
//   (a registered copy of HCounter is kept). Exactly one tick per frame, even when the counter dwells.
//  LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clk, independent of enable.
//  Slot FSM, per rock: IDLE -> FALLING on spawn; FALLING -> IDLE on kill or retire.
//  Spawn: on a frame tick with enable=1, timer increments. When it reaches SPAWN_FRAMES-1 it wraps to 0.
//   At that wrap, the lowest-index IDLE slot loads top=TOP_BOUND and x=LEFT_BOUND+off.
//   off = lfsr[9:0] minus X_SPAN if >= X_SPAN, then clamped to X_SPAN-1;
//   X_SPAN = RIGHT_BOUND-LEFT_BOUND-SIZE.
//   If no slot is IDLE, the spawn is dropped; the timer still wraps.
//  Motion: on a frame tick with enable=1, each FALLING rock does top += SPEED (11-bit arithmetic, no wrap).
//   If the new top+SIZE >= BOTTOM_BOUND, the slot goes IDLE instead and escaped pulses on that clk.
//   Multiple simultaneous retirements produce a single pulse.
//  A rock spawned on a tick does not move until the next tick.
//  kill_mask: bit i clears slot i to IDLE on the next clk edge and does not assert escaped.
//   Kill beats move/retire in the same clk. Kill on an IDLE slot is ignored.
//   A slot killed in the same clk as a spawn is not eligible for that spawn.
//  enable=0: timer, positions and states hold; kill_mask is still honoured; pixel output still active.
//  Pixel test, strict bounds: x < HCounter < x+SIZE && top < VCounter < top+SIZE, FALLING slots only.
//   Result registered: pixel_on/rock_id lag HCounter/VCounter by exactly 1 clk.
//  active_count: registered popcount of FALLING slots, valid 1 clk after the state change.
//  resetn asserted mid-frame: immediate return to reset values; first spawn SPAWN_FRAMES ticks after release.
// TESTING
//  1. Reset, enable=1, run SPAWN_FRAMES frames -> rock 0 FALLING at top=35, x in [144,753],
//     active_count=1, pixel_on high only inside its square, 1 clk late.
//  2. SPEED=1, SIZE=30: 450 further ticks -> top=485 then retires (485+30=515), escaped 1 clk,
//     active_count=0.
//  3. Fill all 4 slots, reach the next spawn wrap -> spawn dropped, active_count stays 4, no slot reloads.
//  4. kill_mask=4'b0010 on the same clk as a frame tick -> slot 1 IDLE, escaped stays 0,
//     slots 0 and 2 still advance by SPEED.
//  5. enable=0 for 100 frames mid-fall -> top/x/timer unchanged, pixel_on still drawn;
//     re-enable resumes from the held top.
//  6. Overlap of rocks 0 and 2 at one pixel -> rock_id=0. Pulse resetn low mid-frame ->
//     all outputs 0 immediately, LFSR=16'hACE1.

Source files
------------

// File: rtl/asteroid_field.sv
// Falling-rock generator for the VGA playfield: N_ROCKS square slots spawn at pseudo-random
// columns once every SPAWN_FRAMES frames, fall SPEED lines per frame and retire at the bottom.
module asteroid_field #(
   parameter int          N_ROCKS      = 4,
   parameter int          SIZE         = 30,
   parameter int          SPEED        = 1,
   parameter int          LEFT_BOUND   = 144,
   parameter int          RIGHT_BOUND  = 784,
   parameter int          TOP_BOUND    = 35,
   parameter int          BOTTOM_BOUND = 515,
   parameter int          SPAWN_FRAMES = 60,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [9:0]         HCounter,
   input  logic [9:0]         VCounter,
   input  logic               enable,
   input  logic [N_ROCKS-1:0] kill_mask,
   output logic               pixel_on,
   output logic [2:0]         rock_id,
   output logic [3:0]         active_count,
   output logic               escaped
);

   localparam int X_SPAN = RIGHT_BOUND - LEFT_BOUND - SIZE;
   localparam int TW     = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_FALLING = 1'b1;

   logic [9:0]         h_prev;
   logic [15:0]        lfsr;
   logic [TW-1:0]      timer;
   logic [N_ROCKS-1:0] state_q, state_d;
   logic [10:0]        top_q [N_ROCKS];
   logic [10:0]        top_d [N_ROCKS];
   logic [10:0]        x_q   [N_ROCKS];
   logic [10:0]        x_d   [N_ROCKS];
   logic [N_ROCKS-1:0] retire;
   logic [N_ROCKS-1:0] spawn_sel;
   logic [10:0]        moved;
   logic [10:0]        off_wrap, spawn_off, spawn_x;
   logic [15:0]        lfsr_next;
   logic               tick, run, wrap;
   logic [10:0]        hpos, vpos;
   logic               hit_any;
   logic [2:0]         hit_id;
   logic [3:0]         cnt_d;

   // The "previous HCounter non-zero" term keeps a dwelling counter from re-triggering.
   assign tick = (HCounter == 10'd0) && (VCounter == 10'd0) && (h_prev != 10'd0);
   assign run  = tick && enable;
   assign wrap = run && (timer == TW'(SPAWN_FRAMES - 1));

   assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   always_comb begin
      off_wrap = {1'b0, lfsr[9:0]};
      if (off_wrap >= 11'(X_SPAN))
         off_wrap = off_wrap - 11'(X_SPAN);
      spawn_off = (off_wrap > 11'(X_SPAN - 1)) ? 11'(X_SPAN - 1) : off_wrap;
   end

   assign spawn_x = 11'(LEFT_BOUND) + spawn_off;

   // Lowest-index IDLE slot; a slot being killed this clk is still FALLING so never selected.
   always_comb begin
      spawn_sel = '0;
      for (int i = N_ROCKS - 1; i >= 0; i--) begin
         if (state_q[i] == S_IDLE) begin
            spawn_sel    = '0;
            spawn_sel[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      top_d   = top_q;
      x_d     = x_q;
      retire  = '0;
      moved   = '0;
      for (int i = 0; i < N_ROCKS; i++) begin
         moved = top_q[i] + 11'(SPEED);
         if (state_q[i] == S_FALLING) begin
            if (kill_mask[i]) begin
               state_d[i] = S_IDLE;
            end else if (run) begin
               if (moved + 11'(SIZE) >= 11'(BOTTOM_BOUND)) begin
                  state_d[i] = S_IDLE;
                  retire[i]  = 1'b1;
               end else begin
                  top_d[i] = moved;
               end
            end
         end else if (wrap && spawn_sel[i]) begin
            state_d[i] = S_FALLING;
            top_d[i]   = 11'(TOP_BOUND);
            x_d[i]     = spawn_x;
         end
      end
   end

   assign hpos = {1'b0, HCounter};
   assign vpos = {1'b0, VCounter};

   // Strict-bounds hit test; iterating downward leaves the lowest index as the winner.
   always_comb begin
      hit_any = 1'b0;
      hit_id  = 3'd0;
      cnt_d   = 4'd0;
      for (int i = N_ROCKS - 1; i >= 0; i--) begin
         if ((state_q[i] == S_FALLING) &&
             (x_q[i] < hpos) && (hpos < x_q[i] + 11'(SIZE)) &&
             (top_q[i] < vpos) && (vpos < top_q[i] + 11'(SIZE))) begin
            hit_any = 1'b1;
            hit_id  = 3'(i);
         end
      end
      for (int i = 0; i < N_ROCKS; i++)
         cnt_d = cnt_d + 4'(state_q[i]);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         h_prev       <= 10'd0;
         lfsr         <= LFSR_SEED;
         timer        <= '0;
         state_q      <= {N_ROCKS{S_IDLE}};
         top_q        <= '{default: 11'(TOP_BOUND)};
         x_q          <= '{default: 11'(LEFT_BOUND)};
         pixel_on     <= 1'b0;
         rock_id      <= 3'd0;
         active_count <= 4'd0;
         escaped      <= 1'b0;
      end else begin
         h_prev       <= HCounter;
         lfsr         <= lfsr_next;
         if (run)
            timer <= wrap ? '0 : timer + TW'(1);
         state_q      <= state_d;
         top_q        <= top_d;
         x_q          <= x_d;
         pixel_on     <= hit_any;
         rock_id      <= hit_id;
         active_count <= cnt_d;
         escaped      <= |retire;
      end
   end

endmodule

// File: tb/tb_asteroid_field.sv
// Directed bench for asteroid_field: a default-parameter instance for spawn, motion, kill,
// freeze and reset, plus a narrow fast-spawn instance where rocks overlap deterministically.
module tb_asteroid_field;

   localparam int X_SPAN = 784 - 144 - 30;

   logic       clk = 1'b0;
   logic       rst_n, rst2_n;
   logic       enable, enable2;
   logic [9:0] hc, vc;
   logic [3:0] kill1, kill2;
   logic       p1, p2, esc1, esc2;
   logic [2:0] id1, id2;
   logic [3:0] ac1, ac2;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [15:0] m_lfsr;
   logic [15:0] lfsr_cap;
   int         x0, x1, x2, x3, x1n, xr;

   typedef struct {
      int h;
      int v;
      int on;
      int id;
   } pix_vec_t;

   pix_vec_t tbl [15];

   always #5 clk = ~clk;

   asteroid_field u_dut (
      .clk(clk), .resetn(rst_n), .HCounter(hc), .VCounter(vc), .enable(enable),
      .kill_mask(kill1), .pixel_on(p1), .rock_id(id1), .active_count(ac1), .escaped(esc1)
   );

   // Narrow field (X_SPAN = 1) pins every spawn to x = 144; spawns every 2 frames.
   asteroid_field #(.RIGHT_BOUND(175), .SPAWN_FRAMES(2)) u_dut2 (
      .clk(clk), .resetn(rst2_n), .HCounter(hc), .VCounter(vc), .enable(enable2),
      .kill_mask(kill2), .pixel_on(p2), .rock_id(id2), .active_count(ac2), .escaped(esc2)
   );

   // Reference Galois LFSR, taps 16,14,13,11.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   function automatic int calc_x(input logic [15:0] l);
      int off;
      off = int'(l[9:0]);
      if (off >= X_SPAN) off = off - X_SPAN;
      if (off > X_SPAN - 1) off = X_SPAN - 1;
      return 144 + off;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic frame_tick(input logic [3:0] k1, input logic [3:0] k2, input int dwell);
      hc = 10'd5; vc = 10'd0;
      @(negedge clk);
      hc = 10'd0; vc = 10'd0; kill1 = k1; kill2 = k2;
      lfsr_cap = m_lfsr;
      @(negedge clk);
      kill1 = 4'd0; kill2 = 4'd0;
      repeat (dwell) @(negedge clk);
   endtask

   task automatic probe(input int h, input int v);
      hc = 10'(h); vc = 10'(v);
      @(negedge clk);
   endtask

   task automatic probe1(input string name, input int h, input int v, input int on, input int id);
      probe(h, v);
      check({name, "_on"}, int'(p1), on);
      check({name, "_id"}, int'(id1), id);
   endtask

   initial begin
      // r0 at (144,39), r2 at (144,35); slot 1 killed on the spawn clk.
      tbl[0]  = '{h: 160, v: 41, on: 1, id: 0};
      tbl[1]  = '{h: 160, v: 38, on: 1, id: 2};
      tbl[2]  = '{h: 160, v: 39, on: 1, id: 2};
      tbl[3]  = '{h: 160, v: 40, on: 1, id: 0};
      tbl[4]  = '{h: 160, v: 36, on: 1, id: 2};
      tbl[5]  = '{h: 160, v: 35, on: 0, id: 0};
      tbl[6]  = '{h: 145, v: 50, on: 1, id: 0};
      tbl[7]  = '{h: 144, v: 50, on: 0, id: 0};
      tbl[8]  = '{h: 173, v: 50, on: 1, id: 0};
      tbl[9]  = '{h: 174, v: 50, on: 0, id: 0};
      tbl[10] = '{h: 160, v: 64, on: 1, id: 0};
      tbl[11] = '{h: 160, v: 66, on: 1, id: 0};
      tbl[12] = '{h: 160, v: 68, on: 1, id: 0};
      tbl[13] = '{h: 160, v: 69, on: 0, id: 0};
      tbl[14] = '{h: 100, v: 50, on: 0, id: 0};

      rst_n = 1'b0; rst2_n = 1'b0; enable = 1'b1; enable2 = 1'b1;
      hc = 10'd5; vc = 10'd0; kill1 = 4'd0; kill2 = 4'd0;
      repeat (3) @(negedge clk);
      check("reset_pixel_on", int'(p1), 0);
      check("reset_rock_id", int'(id1), 0);
      check("reset_active", int'(ac1), 0);
      check("reset_escaped", int'(esc1), 0);

      // Overlap / priority / strict bounds on the narrow instance.
      rst2_n = 1'b1;
      repeat (5) frame_tick(4'd0, 4'd0, 0);
      frame_tick(4'd0, 4'b0010, 0);
      @(negedge clk);
      check("ovl_active", int'(ac2), 2);
      for (int i = 0; i < 15; i++) begin
         probe(tbl[i].h, tbl[i].v);
         n_checks++;
         if (int'(p2) != tbl[i].on || int'(id2) != tbl[i].id) begin
            n_fail++;
            $display("FAIL pix_tbl[%0d] (%0d,%0d): got on=%0d id=%0d expected on=%0d id=%0d",
                     i, tbl[i].h, tbl[i].v, p2, id2, tbl[i].on, tbl[i].id);
         end
      end
      rst2_n = 1'b0;

      // First spawn exactly SPAWN_FRAMES ticks after reset release.
      @(negedge clk);
      rst_n = 1'b1;
      repeat (59) frame_tick(4'd0, 4'd0, 0);
      @(negedge clk);
      check("no_early_spawn", int'(ac1), 0);
      frame_tick(4'd0, 4'd0, 0);
      x0 = calc_x(lfsr_cap);
      @(negedge clk);
      check("spawn_active", int'(ac1), 1);
      probe1("r0_inside", x0 + 1, 36, 1, 0);
      probe1("r0_left_edge", x0, 36, 0, 0);
      probe1("r0_far_corner", x0 + 29, 64, 1, 0);
      probe1("r0_right_edge", x0 + 30, 50, 0, 0);
      probe1("r0_top_edge", x0 + 15, 35, 0, 0);
      probe(x0 + 15, 50);
      hc = 10'(x0 + 15); vc = 10'd100;
      #2;
      check("lag_hold", int'(p1), 1);
      @(negedge clk);
      check("lag_release", int'(p1), 0);

      // Fill all four slots; ticks 61..120 dwell on (0,0) to prove one tick per frame.
      repeat (60) frame_tick(4'd0, 4'd0, 2);
      x1 = calc_x(lfsr_cap);
      repeat (60) frame_tick(4'd0, 4'd0, 0);
      x2 = calc_x(lfsr_cap);
      repeat (60) frame_tick(4'd0, 4'd0, 0);
      x3 = calc_x(lfsr_cap);
      @(negedge clk);
      check("full_active", int'(ac1), 4);

      // Tick 300: spawn dropped.
      repeat (60) frame_tick(4'd0, 4'd0, 0);
      @(negedge clk);
      check("drop_active", int'(ac1), 4);
      probe1("drop_r0_pos", x0 + 1, 276, 1, 0);
      probe1("drop_no_reload", x0 + 1, 36, 0, 0);
      probe1("drop_r3_pos", x3 + 1, 96, 1, 3);

      // Tick 301 with kill on slot 1.
      frame_tick(4'b0010, 4'd0, 0);
      check("kill_no_escape", int'(esc1), 0);
      @(negedge clk);
      check("kill_active", int'(ac1), 3);
      probe1("kill_r0_moved", x0 + 1, 277, 1, 0);
      probe1("kill_r0_top", x0 + 1, 276, 0, 0);
      probe1("kill_r2_moved", x2 + 1, 157, 1, 2);
      probe1("kill_r1_gone", x1 + 1, 218, 0, 0);

      // Freeze for 100 frames.
      enable = 1'b0;
      repeat (100) frame_tick(4'd0, 4'd0, 0);
      probe1("frozen_drawn", x0 + 1, 277, 1, 0);
      probe1("frozen_low_in", x0 + 1, 305, 1, 0);
      probe1("frozen_low_out", x0 + 1, 306, 0, 0);
      check("frozen_active", int'(ac1), 3);
      enable = 1'b1;
      frame_tick(4'd0, 4'd0, 0);
      probe1("resume_old_top", x0 + 1, 277, 0, 0);
      probe1("resume_new_top", x0 + 1, 278, 1, 0);

      // Timer held: next spawn lands on enabled tick 360, into slot 1.
      repeat (57) frame_tick(4'd0, 4'd0, 0);
      @(negedge clk);
      check("timer_held", int'(ac1), 3);
      frame_tick(4'd0, 4'd0, 0);
      x1n = calc_x(lfsr_cap);
      @(negedge clk);
      check("respawn_active", int'(ac1), 4);
      probe1("respawn_slot1", x1n + 1, 36, 1, 1);

      // Retire rock 0 at enabled tick 510 (top 485 + 30 = 515).
      repeat (149) frame_tick(4'd0, 4'd0, 0);
      check("no_early_escape", int'(esc1), 0);
      probe1("r0_last_pos", x0 + 1, 485, 1, 0);
      frame_tick(4'd0, 4'd0, 0);
      check("escape_pulse", int'(esc1), 1);
      @(negedge clk);
      check("escape_width", int'(esc1), 0);
      check("retire_active", int'(ac1), 3);
      probe1("retired_gone", x0 + 1, 486, 0, 0);

      // Asynchronous reset in mid-frame.
      probe1("pre_reset_r3", x3 + 1, 306, 1, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_pixel_on", int'(p1), 0);
      check("areset_rock_id", int'(id1), 0);
      check("areset_active", int'(ac1), 0);
      check("areset_escaped", int'(esc1), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (59) frame_tick(4'd0, 4'd0, 0);
      @(negedge clk);
      check("post_reset_no_spawn", int'(ac1), 0);
      frame_tick(4'd0, 4'd0, 0);
      xr = calc_x(lfsr_cap);
      @(negedge clk);
      check("post_reset_active", int'(ac1), 1);
      probe1("post_reset_in", xr + 1, 36, 1, 0);
      probe1("post_reset_edge", xr, 36, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
